// File: rtl/rv_ooo_pkg.sv
// Shared out-of-order core types: physical register indices and free-list sizing.
package rv_ooo_pkg;

   localparam int PREG_W     = 6;
   localparam int NUM_PREG   = 64;
   localparam int FREE_DEPTH = 32;
   localparam int PTR_W      = 5;

   typedef logic [PREG_W-1:0] preg_t;
   typedef logic [PTR_W-1:0]  fl_ptr_t;
   typedef logic [PTR_W:0]    fl_count_t;

   localparam preg_t PREG_ZERO = 6'd0;

   // Architectural register specifier and the sr/dr/old_dr bundle exchanged between rename and ROB
   typedef logic [4:0] areg_t;

   typedef struct packed {
      preg_t sr1;
      preg_t sr2;
      preg_t dr;
      preg_t old_dr;
   } rename_map_t;

endpackage

// File: rtl/preg_free_list_rel_qualify.sv
// Qualifies the two retire release slots and compacts the survivors into write lanes.
import rv_ooo_pkg::*;

module preg_free_list_rel_qualify (
   input  logic                rel0_valid,
   input  logic [PREG_W-1:0]   rel0_preg,
   input  logic                rel1_valid,
   input  logic [PREG_W-1:0]   rel1_preg,
   input  logic [NUM_PREG-1:0] free_bit,
   input  logic [PTR_W:0]      count,
   input  logic                pop,
   output logic                wr0_en,
   output logic [PREG_W-1:0]   wr0_preg,
   output logic                wr1_en,
   output logic [PREG_W-1:0]   wr1_preg,
   output logic [1:0]          push_cnt,
   output logic                dbl_free,
   output logic                overflow
);

   logic       rel0_ok;
   logic       rel1_ok;
   logic       rel0_eff;
   logic       rel1_eff;
   logic       keep0;
   logic       keep1;
   logic [6:0] room;

   // Decide which releases are genuine, which hit room limits, and pack them oldest-first
   always_comb begin
      rel0_ok  = rel0_valid && (rel0_preg != PREG_ZERO);
      rel1_ok  = rel1_valid && (rel1_preg != PREG_ZERO);
      rel0_eff = rel0_ok && !free_bit[rel0_preg];
      rel1_eff = rel1_ok && !free_bit[rel1_preg] && !(rel0_eff && (rel1_preg == rel0_preg));
      dbl_free = (rel0_ok && !rel0_eff) || (rel1_ok && !rel1_eff);

      room  = 7'd32 - {1'b0, count} + {6'd0, pop};
      keep0 = rel0_eff && (room != 7'd0);
      keep1 = rel1_eff && (room >= (keep0 ? 7'd2 : 7'd1));
      overflow = (rel0_eff && !keep0) || (rel1_eff && !keep1);

      wr0_en   = keep0 || keep1;
      wr0_preg = keep0 ? rel0_preg : rel1_preg;
      wr1_en   = keep0 && keep1;
      wr1_preg = rel1_preg;
      push_cnt = {1'b0, keep0} + {1'b0, keep1};
   end

endmodule

// File: rtl/preg_free_list.sv
// Circular free list of physical registers: rename pops one per cycle, retire pushes up to two.
import rv_ooo_pkg::*;

module preg_free_list (
   input  logic              clk,
   input  logic              rst,
   input  logic              alloc_req,
   output logic              alloc_valid,
   output logic [PREG_W-1:0] alloc_preg,
   input  logic              rel0_valid,
   input  logic [PREG_W-1:0] rel0_preg,
   input  logic              rel1_valid,
   input  logic [PREG_W-1:0] rel1_preg,
   output logic [PTR_W:0]    free_count,
   output logic              stall,
   output logic              err_double_free,
   output logic              err_overflow
);

   preg_t                mem_q [FREE_DEPTH];
   preg_t                mem_d [FREE_DEPTH];
   logic [PTR_W-1:0]     head_q, head_d;
   logic [PTR_W-1:0]     tail_q, tail_d;
   logic [PTR_W:0]       count_q, count_d;
   logic [NUM_PREG-1:0]  free_bit_q, free_bit_d;
   logic                 err_double_free_q, err_double_free_d;
   logic                 err_overflow_q, err_overflow_d;

   logic                 pop;
   logic                 wr0_en, wr1_en;
   logic [PREG_W-1:0]    wr0_preg, wr1_preg;
   logic [1:0]           push_cnt;
   logic                 dbl_free, overflow;

   assign alloc_valid     = (count_q != '0);
   assign alloc_preg      = mem_q[head_q];
   assign free_count      = count_q;
   assign stall           = ~alloc_valid;
   assign err_double_free = err_double_free_q;
   assign err_overflow    = err_overflow_q;
   assign pop             = alloc_req && alloc_valid;

   preg_free_list_rel_qualify u_rel_qualify (
      .rel0_valid (rel0_valid),
      .rel0_preg  (rel0_preg),
      .rel1_valid (rel1_valid),
      .rel1_preg  (rel1_preg),
      .free_bit   (free_bit_q),
      .count      (count_q),
      .pop        (pop),
      .wr0_en     (wr0_en),
      .wr0_preg   (wr0_preg),
      .wr1_en     (wr1_en),
      .wr1_preg   (wr1_preg),
      .push_cnt   (push_cnt),
      .dbl_free   (dbl_free),
      .overflow   (overflow)
   );

   // Next-state: pop from head, append qualified releases at tail, keep free flags in step
   always_comb begin
      mem_d      = mem_q;
      free_bit_d = free_bit_q;
      head_d     = head_q;
      tail_d     = tail_q + PTR_W'(push_cnt);
      count_d    = count_q - {{PTR_W{1'b0}}, pop} + {{(PTR_W-1){1'b0}}, push_cnt};

      if (pop) begin
         head_d = head_q + 1'b1;
         free_bit_d[mem_q[head_q]] = 1'b0;
      end
      if (wr0_en) begin
         mem_d[tail_q]        = wr0_preg;
         free_bit_d[wr0_preg] = 1'b1;
      end
      if (wr1_en) begin
         mem_d[tail_q + 1'b1] = wr1_preg;
         free_bit_d[wr1_preg] = 1'b1;
      end

      err_double_free_d = dbl_free;
      err_overflow_d    = overflow;
   end

   // State registers; reset seeds the list with p32..p63, the regs not holding architectural state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < FREE_DEPTH; i++) begin
            mem_q[i] <= preg_t'(FREE_DEPTH + i);
         end
         head_q            <= '0;
         tail_q            <= '0;
         count_q           <= (PTR_W+1)'(FREE_DEPTH);
         free_bit_q        <= {{(NUM_PREG-FREE_DEPTH){1'b1}}, {FREE_DEPTH{1'b0}}};
         err_double_free_q <= 1'b0;
         err_overflow_q    <= 1'b0;
      end else begin
         mem_q             <= mem_d;
         head_q            <= head_d;
         tail_q            <= tail_d;
         count_q           <= count_d;
         free_bit_q        <= free_bit_d;
         err_double_free_q <= err_double_free_d;
         err_overflow_q    <= err_overflow_d;
      end
   end

   // The occupancy counter must always agree with the authoritative free flags
   count_matches_free_bits: assert property (@(posedge clk) disable iff (rst)
      (32'(count_q) == $countones(free_bit_q)) && (count_q <= 6'd32));

endmodule
